// File: rtl/grant_lock.sv
// grant_lock
// Registered grant-holding stage placed right after a combinational
// fixed-priority arbiter. It captures the arbiter's grant, keeps it with a
// single owner for several cycles and releases it in one of three cases:
// the owner signals completion, the owner drops its request, or the hold
// limit runs out.
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous, active-high reset
//   req_i      raw request vector (same vector the arbiter sees)
//   arb_gnt_i  arbiter grant, one-hot or zero, bit 0 highest priority
//   done_i     owner finished; only looked at while a grant is held
//   gnt_o      registered one-hot locked grant, zero when idle
//   gnt_id_o   binary index of the owner, zero when idle
//   busy_o     high while a grant is held
//   timeout_o  one-cycle pulse after a forced release by the hold limit
module grant_lock #(
  parameter int NUM_PORTS = 4,
  parameter int MAX_HOLD  = 8,
  parameter int ID_W      = $clog2(NUM_PORTS)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_PORTS-1:0] req_i,
  input  logic [NUM_PORTS-1:0] arb_gnt_i,
  input  logic                 done_i,
  output logic [NUM_PORTS-1:0] gnt_o,
  output logic [ID_W-1:0]      gnt_id_o,
  output logic                 busy_o,
  output logic                 timeout_o
);

  // Counter only needs to reach MAX_HOLD-1, so it can never wrap.
  localparam int CNT_W = $clog2(MAX_HOLD + 1);

  typedef enum logic {
    IDLE,
    OWNED
  } state_t;

  state_t                 state_reg;
  logic [NUM_PORTS-1:0]   gnt_reg;
  logic [ID_W-1:0]        id_reg;
  logic [CNT_W-1:0]       cnt_reg;
  logic                   busy_reg;
  logic                   timeout_reg;

  logic [NUM_PORTS-1:0]   lock_mask;
  logic [ID_W-1:0]        lock_id;
  logic                   owner_req;
  logic                   hold_expired;
  logic                   release_now;
  logic                   force_release;

  // Keep only the lowest set bit of the arbiter grant, so a malformed
  // multi-hot grant still produces a one-hot lock.
  generate
    for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_low
      if (gi == 0) begin : g_first
        assign lock_mask[gi] = arb_gnt_i[gi];
      end else begin : g_rest
        assign lock_mask[gi] = arb_gnt_i[gi] & ~(|arb_gnt_i[gi-1:0]);
      end
    end
  endgenerate

  always_comb begin
    lock_id = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (lock_mask[i]) begin
        lock_id = ID_W'(i);
      end
    end
  end

  // Owner still requesting: the held grant is one-hot, so masking the
  // request vector with it selects the owner's request bit.
  assign owner_req     = |(req_i & gnt_reg);
  assign hold_expired  = (cnt_reg == CNT_W'(MAX_HOLD - 1));
  assign release_now   = done_i | ~owner_req | hold_expired;
  // Timeout only when neither completion nor request drop explains the release.
  assign force_release = ~done_i & owner_req & hold_expired;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg   <= IDLE;
      gnt_reg     <= '0;
      id_reg      <= '0;
      cnt_reg     <= '0;
      busy_reg    <= 1'b0;
      timeout_reg <= 1'b0;
    end else begin
      timeout_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (|arb_gnt_i) begin
            state_reg <= OWNED;
            gnt_reg   <= lock_mask;
            id_reg    <= lock_id;
            cnt_reg   <= '0;
            busy_reg  <= 1'b1;
          end
        end
        OWNED: begin
          // arb_gnt_i is ignored here: no preemption while owned.
          if (release_now) begin
            // Returning to IDLE costs one bubble cycle before the next lock.
            state_reg   <= IDLE;
            gnt_reg     <= '0;
            id_reg      <= '0;
            cnt_reg     <= '0;
            busy_reg    <= 1'b0;
            timeout_reg <= force_release;
          end else begin
            cnt_reg <= cnt_reg + CNT_W'(1);
          end
        end
      endcase
    end
  end

  assign gnt_o     = gnt_reg;
  assign gnt_id_o  = id_reg;
  assign busy_o    = busy_reg;
  assign timeout_o = timeout_reg;

endmodule

// File: doc/grant_lock.md
Name: grant_lock

Overview:
- Registered grant-holding stage that sits directly downstream of the combinational fixed-priority arbiter.
- It samples the arbiter's one-hot grant, locks it to a single owner, and holds it until the owner signals completion, drops its request, or exceeds a hold limit.
- It turns the arbiter's per-cycle grant into a stable, multi-cycle ownership grant for the shared resource.

Parameters:
- NUM_PORTS, 4, number of requesters. Must be >= 2.
- MAX_HOLD, 8, maximum cycles one owner may hold the grant before forced release. Must be >= 1.
- ID_W, $clog2(NUM_PORTS), width of the owner index output.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- req_i  input  NUM_PORTS  raw request vector, same vector that feeds the arbiter
- arb_gnt_i  input  NUM_PORTS  arbiter grant; one-hot or zero; bit 0 highest priority
- done_i  input  1  current owner has finished; sampled only in OWNED
- gnt_o  output  NUM_PORTS  registered one-hot locked grant, zero when idle
- gnt_id_o  output  ID_W  binary index of the owner; 0 when idle
- busy_o  output  1  high while a grant is held (equals |gnt_o)
- timeout_o  output  1  one-cycle pulse when a grant is force-released by MAX_HOLD

Behaviour:
- Reset (asynchronous assert, synchronous-to-clk deassert use):
  - state=IDLE, gnt_o=0, gnt_id_o=0, busy_o=0, timeout_o=0, hold counter=0.
  - Reset mid-grant drops ownership immediately, with no timeout pulse.
- States: IDLE, OWNED. All outputs are registered.
- IDLE:
  - If arb_gnt_i != 0, then on the next edge: gnt_o=arb_gnt_i, gnt_id_o=index, counter=0, go to OWNED.
  - Latency from arb_gnt_i to gnt_o is exactly 1 cycle.
  - If arb_gnt_i is not one-hot (defensive case), lock the lowest set bit only.
- OWNED, release conditions, evaluated each cycle with priority done > request drop > timeout:
  - a) done_i=1 -> release.
  - b) req_i[gnt_id_o]=0 -> release.
  - c) counter==MAX_HOLD-1 with neither a) nor b) -> release and pulse timeout_o=1 on the same edge that clears gnt_o.
  - Otherwise counter increments; gnt_o is held stable and arb_gnt_i is ignored, even if a higher-priority port requests.
- Release: next edge sets gnt_o=0, gnt_id_o=0, state=IDLE.
  - Mandatory one-cycle bubble: no new grant can be locked on the release edge.
  - The earliest next lock is the edge after that.
- Hold time:
  - A grant is visible on gnt_o for at most MAX_HOLD cycles.
  - A grant is visible for at least 1 cycle.
- Counter:
  - Width $clog2(MAX_HOLD+1).
  - Saturates by construction, never wraps.
- timeout_o:
  - High for exactly one cycle, in the first IDLE cycle after a forced release.
  - Low at all other times.
- Invariants: gnt_o is zero or one-hot; busy_o == |gnt_o; gnt_id_o matches gnt_o.
- Simultaneous events:
  - done_i together with counter==MAX_HOLD-1 is a normal release (timeout_o=0).
  - done_i asserted in IDLE is ignored.

Test Plan:
- Reset then idle: reset=1 with req_i=4'b1111 -> gnt_o=0, busy_o=0, timeout_o=0. Release reset, req_i=0 -> outputs stay 0.
- Single lock: req_i=4'b0100, arb_gnt_i=4'b0100 at cycle 0 -> gnt_o=4'b0100, gnt_id_o=2 at cycle 1. done_i=1 at cycle 3 -> gnt_o=0 at cycle 4.
- Priority preemption blocked: owner port 2, then req_i=4'b0101 with arb_gnt_i=4'b0001 -> gnt_o stays 4'b0100 until done_i. After the bubble cycle, gnt_o=4'b0001.
- Timeout: MAX_HOLD=8, owner port 1 with req held, no done -> gnt_o=4'b0010 for exactly 8 cycles, then gnt_o=0 and timeout_o=1 for one cycle.
- Request drop: owner port 3, req_i[3] deasserted at cycle 5 -> gnt_o=0 at cycle 6, timeout_o=0.
- Reset mid-grant: owner port 0 at count 4, reset pulsed asynchronously -> gnt_o=0 immediately, no timeout pulse, relock 1 cycle after reset deasserts with arb_gnt_i=4'b0001.
